// File: rtl/bus_width_pkg.sv
// Shared helpers for the bus width increase/decrease blocks:
// beat count, pointer width, slice fill order.
package bus_width_pkg;

  typedef enum logic {
    FILL_LSB_FIRST,
    FILL_MSB_FIRST
  } fill_order_e;

  function automatic int beats(int size_in, int size_out);
    return size_out / size_in;
  endfunction

  // Pointer width, never below one bit so BEATS==1 still has a register.
  function automatic int ptr_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_width_increase.sv
// Narrow-to-wide deserialiser: packs SIZE_OUT/SIZE_IN input beats into one
// output word, valid/ready on both sides, full throughput.
// Ports:
//   clk, rst (async, active-high)
//   input_valid/input_ready/data_in[SIZE_IN]      narrow beat side
//   output_valid/output_ready/data_out[SIZE_OUT]  wide word side
//   input_last, output_count  only with BUS_WIDTH_INCREASE_FLUSH_EN defined
// Macro BUS_WIDTH_INCREASE_FLUSH_EN enables partial-word flush on input_last.
module bus_width_increase
  import bus_width_pkg::*;
#(
  parameter int SIZE_IN       = 8,
  parameter int SIZE_OUT      = 32,
  parameter bit LITTLE_ENDIAN = 1'b1,
  localparam int BEATS = beats(SIZE_IN, SIZE_OUT),
  localparam int CW    = $clog2(BEATS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                input_ready,
  input  logic                input_valid,
  input  logic [SIZE_IN-1:0]  data_in,
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
  input  logic                input_last,
  output logic [CW-1:0]       output_count,
`endif
  input  logic                output_ready,
  output logic                output_valid,
  output logic [SIZE_OUT-1:0] data_out
);

  localparam int PW = ptr_w(BEATS);
  localparam fill_order_e ORDER =
    LITTLE_ENDIAN ? FILL_LSB_FIRST : FILL_MSB_FIRST;

  if (SIZE_OUT % SIZE_IN != 0) begin : g_bad_size
    $error("SIZE_OUT must be a multiple of SIZE_IN");
  end

  logic [PW-1:0]       ptr_q;
  logic [SIZE_OUT-1:0] buf_q;
  logic [SIZE_OUT-1:0] word;
  logic                last_beat;
  logic                complete;
  logic                in_hs;
  logic                out_hs;

  function automatic int slot(int i);
    return (ORDER == FILL_LSB_FIRST) ? i : BEATS - 1 - i;
  endfunction

  assign last_beat = (ptr_q == PW'(BEATS - 1));

`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
  assign complete = last_beat | input_last;
`else
  assign complete = last_beat;
`endif

  // Only a word-completing beat has to wait for the output register.
  assign input_ready = !(complete && output_valid && !output_ready);
  assign in_hs       = input_valid & input_ready;
  assign out_hs      = output_valid & output_ready;

  // Buffer with the current beat merged in; on a flush the slices
  // beyond the pointer hold stale data and are cleared.
  always_comb begin
    word = buf_q;
    for (int i = 0; i < BEATS; i++) begin
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
      if (PW'(i) > ptr_q)
        word[slot(i)*SIZE_IN +: SIZE_IN] = '0;
`endif
      if (PW'(i) == ptr_q)
        word[slot(i)*SIZE_IN +: SIZE_IN] = data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      buf_q        <= '0;
      output_valid <= 1'b0;
      data_out     <= '0;
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
      output_count <= '0;
`endif
    end else begin
      if (out_hs)
        output_valid <= 1'b0;
      if (in_hs) begin
        buf_q <= word;
        if (complete) begin
          ptr_q        <= '0;
          output_valid <= 1'b1;
          data_out     <= word;
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
          output_count <= CW'(ptr_q) + CW'(1);
`endif
        end else begin
          ptr_q <= ptr_q + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_width_increase.sv
// Scoreboard bench for bus_width_increase: LE and BE instances share
// stimulus; a queue model predicts words, handshakes and word counts.
module tb_bus_width_increase;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        input_valid;
  logic [7:0]  data_in;
  logic        output_ready;
  logic        rdy_le, rdy_be;
  logic        ov_le, ov_be;
  logic [31:0] do_le, do_be;
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
  logic        input_last;
  logic [2:0]  cnt_le, cnt_be;
`endif

  always #5 clk = ~clk;

  bus_width_increase #(
    .SIZE_IN(8), .SIZE_OUT(32), .LITTLE_ENDIAN(1'b1)
  ) u_le (
    .clk(clk),
    .rst(rst),
    .input_ready(rdy_le),
    .input_valid(input_valid),
    .data_in(data_in),
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
    .input_last(input_last),
    .output_count(cnt_le),
`endif
    .output_ready(output_ready),
    .output_valid(ov_le),
    .data_out(do_le)
  );

  bus_width_increase #(
    .SIZE_IN(8), .SIZE_OUT(32), .LITTLE_ENDIAN(1'b0)
  ) u_be (
    .clk(clk),
    .rst(rst),
    .input_ready(rdy_be),
    .input_valid(input_valid),
    .data_in(data_in),
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
    .input_last(input_last),
    .output_count(cnt_be),
`endif
    .output_ready(output_ready),
    .output_valid(ov_be),
    .data_out(do_be)
  );

  typedef struct packed {
    logic [31:0] le;
    logic [31:0] be;
    logic [2:0]  cnt;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  int          nwords = 0;
  exp_t        sb[$];
  logic [7:0]  part[$];
  bit          occ;
  logic [31:0] last_le, last_be;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output word is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov_le && output_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", do_le, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        check("word_le", do_le, e.le);
        check("word_be", do_be, e.be);
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
        check("count_le", 32'(cnt_le), 32'(e.cnt));
        check("count_be", 32'(cnt_be), 32'(e.cnt));
`endif
        last_le = do_le;
        last_be = do_be;
        nwords++;
      end
    end
  end

  // Word the spec's packing rule gives for the beats gathered so far.
  function automatic exp_t build();
    exp_t e;
    e = '0;
    foreach (part[k]) begin
      e.le |= 32'(part[k]) << (8 * k);
      e.be |= 32'(part[k]) << (8 * (NB - 1 - k));
    end
    e.cnt = 3'(part.size());
    return e;
  endfunction

  // One cycle: drive after the edge, check and update model at negedge.
  task automatic step(input bit v, input logic [7:0] d,
                      input bit ordy, input bit last, output bit acc);
    bit lb;
    bit cmp;
    bit exp_rdy;
    @(posedge clk);
    #1;
    input_valid  = v;
    data_in      = d;
    output_ready = ordy;
    lb = 1'b0;
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
    input_last = last;
    lb = last;
`endif
    @(negedge clk);
    cmp     = (part.size() == NB - 1) || lb;
    exp_rdy = !(cmp && occ && !ordy);
    check("input_ready_le", 32'(rdy_le), 32'(exp_rdy));
    check("input_ready_be", 32'(rdy_be), 32'(exp_rdy));
    check("output_valid_le", 32'(ov_le), 32'(occ));
    check("output_valid_be", 32'(ov_be), 32'(occ));
    if (occ && ordy) occ = 1'b0;
    acc = v && exp_rdy;
    if (acc) begin
      part.push_back(d);
      if (cmp) begin
        sb.push_back(build());
        part.delete();
        occ = 1'b1;
      end
    end
  endtask

  task automatic drain(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0, a);
  endtask

  initial begin
    bit a;
    int idx;
    int w0;
    rst = 1'b0;
    input_valid = 1'b0;
    data_in = '0;
    output_ready = 1'b0;
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
    input_last = 1'b0;
`endif
    occ = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_valid", 32'(ov_le), 32'd0);
    check("rst_data", do_le, 32'd0);
    check("rst_ready", 32'(rdy_le), 32'd1);
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
    check("rst_count", 32'(cnt_le), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Basic fill, both orders.
    step(1'b1, 8'h11, 1'b1, 1'b0, a);
    step(1'b1, 8'h22, 1'b1, 1'b0, a);
    step(1'b1, 8'h33, 1'b1, 1'b0, a);
    step(1'b1, 8'h44, 1'b1, 1'b0, a);
    drain(2);
    check("fill_le", last_le, 32'h4433_2211);
    check("fill_be", last_be, 32'h1122_3344);

    // Streaming: three words back to back.
    w0 = nwords;
    for (int i = 1; i <= 12; i++) step(1'b1, 8'(i), 1'b1, 1'b0, a);
    drain(2);
    check("stream_words", 32'(nwords - w0), 32'd3);
    check("stream_last", last_le, 32'h0C0B_0A09);

    // Backpressure: word 1 held while word 2 is gathered.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h51 + 8'(i), 1'b0, 1'b0, a);
    idx = 0;
    for (int c = 0; c < 12 && idx < 4; c++) begin
      step(1'b1, 8'h61 + 8'(idx), c >= 6, 1'b0, a);
      if (a) idx++;
    end
    check("bp_beats", 32'(idx), 32'd4);
    drain(3);
    check("bp_last_le", last_le, 32'h6463_6261);

    // Async reset with a word pending and a partial word.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h81 + 8'(i), 1'b0, 1'b0, a);
    step(1'b1, 8'h71, 1'b0, 1'b0, a);
    step(1'b1, 8'h72, 1'b0, 1'b0, a);
    @(posedge clk);
    #1 input_valid = 1'b0;
    check("pre_rst_valid", 32'(ov_le), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(ov_le), 32'd0);
    sb.delete();
    part.delete();
    occ = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 8'hA1 + 8'(i), 1'b1, 1'b0, a);
    drain(2);
    check("post_rst_le", last_le, 32'hA4A3_A2A1);

`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
    step(1'b1, 8'hAA, 1'b1, 1'b0, a);
    step(1'b1, 8'hBB, 1'b1, 1'b1, a);
    drain(2);
    check("flush_le", last_le, 32'h0000_BBAA);
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC1 + 8'(i), 1'b1, 1'b0, a);
    drain(2);
    check("flush_full", last_le, 32'hC4C3_C2C1);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, a);
    drain(4);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
